// File: rtl/lstm_sched_pkg.sv
// lstm_sched_pkg: shared types for the LSTM sequence scheduler
package lstm_sched_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WAIT, DONE} sched_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, power-of-two depth
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = DEPTH[AW:0];
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic do_push, do_pop;
    assign full = count == CAP;
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd];
    // storage array, no reset needed since reads are qualified by count
    always_ff @(posedge clk)
        if (do_push) mem[wr] <= din;
    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
endmodule

// File: rtl/lstm_sequence_scheduler.sv
// lstm_sequence_scheduler: streams whole sequences one sample at a time through lstm_layers
module lstm_sequence_scheduler
    import lstm_sched_pkg::*;
#(
    parameter int LAYERS    = 4,
    parameter int WIDTH     = 16,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] cfg_seq_len,
    input  logic                 cfg_clear_state,
    output logic                 busy,
    output logic                 done,
    output logic                 protocol_err,
    input  logic [WIDTH-1:0]     s_x_data,
    input  logic                 s_x_valid,
    output logic                 s_x_ready,
    input  logic                 lstm_ready,
    output logic [WIDTH-1:0]     state_data,
    output logic [LAYERS-1:0]    c_in_valid,
    output logic [LAYERS-1:0]    h_in_valid,
    output logic [WIDTH-1:0]     x_in,
    output logic                 x_in_valid,
    input  logic [WIDTH-1:0]     lstm_y_out,
    input  logic                 lstm_valid,
    output logic [WIDTH-1:0]     m_y_data,
    output logic                 m_y_last,
    output logic                 m_y_valid,
    input  logic                 m_y_ready
);
    localparam int IW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int ICW = $clog2(IN_DEPTH) + 1;
    localparam int OCW = $clog2(OUT_DEPTH) + 1;
    localparam logic [OCW-1:0] OUT_CAP = OUT_DEPTH[OCW-1:0];
    localparam logic [IW-1:0] LAST_LAYER = IW'(LAYERS - 1);

    sched_state_t state, next;
    logic [IW-1:0] idx;
    logic [LEN_WIDTH-1:0] seq_len, issued, received;
    logic [LAYERS-1:0] strobe;
    logic in_full, in_empty, out_full, out_empty;
    logic [ICW-1:0] in_count;
    logic [OCW-1:0] out_count;
    logic [WIDTH-1:0] head;
    logic [WIDTH:0] out_dout;
    logic accept, clear_go, issue, result, last;
    logic unused_ok;

    assign unused_ok = ^{in_count, out_full};
    assign accept = state == IDLE && start;
    assign clear_go = state == CLEAR && lstm_ready;
    assign issue = state == ISSUE && !in_empty && lstm_ready && out_count < OUT_CAP && issued != seq_len;
    assign result = state == WAIT && lstm_valid;
    assign last = received == seq_len - LEN_WIDTH'(1);
    assign busy = state != IDLE;
    assign s_x_ready = !in_full;
    assign state_data = '0;
    assign c_in_valid = strobe;
    assign h_in_valid = strobe;
    assign m_y_valid = !out_empty;
    assign {m_y_last, m_y_data} = m_y_valid ? out_dout : '0;

    sync_fifo #(.W(WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(s_x_valid && !in_full), .din(s_x_data),
        .pop(issue), .dout(head),
        .full(in_full), .empty(in_empty), .count(in_count)
    );

    sync_fifo #(.W(WIDTH + 1), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk(clk), .rst_n(rst_n),
        .push(result), .din({last, lstm_y_out}),
        .pop(m_y_valid && m_y_ready), .dout(out_dout),
        .full(out_full), .empty(out_empty), .count(out_count)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next;

    // next-state: one sample in flight, clear walks layers only while the datapath is ready
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = (cfg_seq_len == '0) ? DONE : cfg_clear_state ? CLEAR : ISSUE;
            CLEAR:   if (clear_go && idx == LAST_LAYER) next = ISSUE;
            ISSUE:   if (issue) next = WAIT;
            WAIT:    if (lstm_valid) next = last ? DONE : ISSUE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // registered strobes, sequence counters and the sticky protocol error
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx <= '0;
            seq_len <= '0;
            issued <= '0;
            received <= '0;
            strobe <= '0;
            x_in <= '0;
            x_in_valid <= 1'b0;
            done <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            strobe <= '0;
            x_in_valid <= 1'b0;
            done <= next == DONE;
            if (accept) begin
                seq_len <= cfg_seq_len;
                issued <= '0;
                received <= '0;
                idx <= '0;
            end
            if (clear_go) begin
                strobe <= LAYERS'(1) << idx;
                idx <= idx + 1'b1;
            end
            if (issue) begin
                x_in <= head;
                x_in_valid <= 1'b1;
                issued <= issued + 1'b1;
            end
            if (result) received <= received + 1'b1;
            protocol_err <= (protocol_err && !accept) || (lstm_valid && state != WAIT);
        end
endmodule

// File: tb/tb_lstm_sequence_scheduler.sv
// tb_lstm_sequence_scheduler: directed bench with a fixed-latency y=x+1 datapath model
module tb_lstm_sequence_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] cfg_seq_len = '0;
    logic cfg_clear_state = 1'b0;
    logic busy, done, protocol_err;
    logic [15:0] s_x_data = '0;
    logic s_x_valid = 1'b0;
    logic s_x_ready;
    logic lstm_ready = 1'b1;
    logic [15:0] state_data;
    logic [3:0] c_in_valid, h_in_valid;
    logic [15:0] x_in;
    logic x_in_valid;
    logic [15:0] lstm_y_out;
    logic lstm_valid;
    logic [15:0] m_y_data;
    logic m_y_last, m_y_valid;
    logic m_y_ready = 1'b1;

    logic m_valid = 1'b0, inj_valid = 1'b0;
    logic [15:0] m_y = '0, inj_y = '0, my;
    int gen = 0, mg;
    int cyc = 0, vecs = 0, errs = 0;
    int outst = 0, overlap = 0, ch_err = 0, dn = 0, dc = 0, s;
    logic [15:0] xq[$];
    int xc[$];
    logic [3:0] sq[$];
    int sc[$];
    logic [16:0] yq[$];

    assign lstm_valid = m_valid | inj_valid;
    assign lstm_y_out = inj_valid ? inj_y : m_y;

    lstm_sequence_scheduler #(.LAYERS(4), .WIDTH(16), .IN_DEPTH(16), .OUT_DEPTH(2), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_seq_len(cfg_seq_len),
        .cfg_clear_state(cfg_clear_state), .busy(busy), .done(done), .protocol_err(protocol_err),
        .s_x_data(s_x_data), .s_x_valid(s_x_valid), .s_x_ready(s_x_ready),
        .lstm_ready(lstm_ready), .state_data(state_data),
        .c_in_valid(c_in_valid), .h_in_valid(h_in_valid),
        .x_in(x_in), .x_in_valid(x_in_valid),
        .lstm_y_out(lstm_y_out), .lstm_valid(lstm_valid),
        .m_y_data(m_y_data), .m_y_last(m_y_last), .m_y_valid(m_y_valid), .m_y_ready(m_y_ready)
    );

    always #5 clk = ~clk;

    // cycle index, stable away from the rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // mid-cycle monitor logging issues, strobes, handshaked results and done pulses
    always @(negedge clk) begin
        if (!rst_n) outst = 0;
        else begin
            if (lstm_valid && outst > 0) outst--;
            if (x_in_valid) begin
                if (outst != 0) overlap++;
                outst++;
                xq.push_back(x_in);
                xc.push_back(cyc);
            end
            if (c_in_valid != 4'd0) begin
                sq.push_back(c_in_valid);
                sc.push_back(cyc);
            end
            if (c_in_valid != h_in_valid) ch_err++;
            if (m_y_valid && m_y_ready) yq.push_back({m_y_last, m_y_data});
            if (done) begin
                dn++;
                dc = cyc;
            end
        end
    end

    // datapath model: answers x+1 five cycles after each issued sample
    initial forever begin
        @(negedge clk);
        if (x_in_valid && rst_n) begin
            mg = gen;
            my = x_in + 16'h0001;
            repeat (5) @(posedge clk);
            #2;
            if (mg == gen) begin
                m_y = my;
                m_valid = 1'b1;
                @(posedge clk);
                #2;
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        s_x_data = v;
        s_x_valid = 1'b1;
        tick();
        s_x_valid = 1'b0;
    endtask

    task automatic go(input logic [15:0] len, input logic clr, output int sc0);
        cfg_seq_len = len;
        cfg_clear_state = clr;
        start = 1'b1;
        sc0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
    endtask

    task automatic clr_logs();
        xq.delete(); xc.delete(); sq.delete(); sc.delete(); yq.delete();
        dn = 0; overlap = 0; ch_err = 0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s_x_ready", s_x_ready, 1);
        chk("rst_m_y_valid", m_y_valid, 0);
        chk("rst_m_y_data", {m_y_last, m_y_data}, 0);
        chk("rst_x_in", {x_in_valid, x_in}, 0);
        chk("rst_strobes", {c_in_valid, h_in_valid}, 0);
        chk("rst_perr", protocol_err, 0);
        chk("state_data", state_data, 0);
        rst_n = 1'b1;
        tick();

        inj_y = 16'hABCD;
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        chk("spur_perr", protocol_err, 1);
        chk("spur_no_push", m_y_valid, 0);
        tick();
        chk("spur_sticky", protocol_err, 1);

        clr_logs();
        push(16'h0100);
        push(16'h0200);
        push(16'h0300);
        go(16'd3, 1'b1, s);
        chk("basic_perr_cleared", protocol_err, 0);
        chk("basic_busy", busy, 1);
        wait_done("basic_done");
        tick();
        chk("basic_busy_low", busy, 0);
        chk("basic_strobe_cnt", sq.size(), 4);
        if (sq.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("basic_strobe_layer", sq[i], 4'b0001 << i);
                chk("basic_strobe_consec", sc[i], sc[0] + i);
            end
        chk("basic_c_eq_h", ch_err, 0);
        chk("basic_x_cnt", xq.size(), 3);
        if (xq.size() == 3) begin
            chk("basic_x0", xq[0], 16'h0100);
            chk("basic_x1", xq[1], 16'h0200);
            chk("basic_x2", xq[2], 16'h0300);
            chk("basic_x0_cycle", xc[0], s + 6);
            chk("basic_x1_cycle", xc[1], xc[0] + 7);
            chk("basic_done_cycle", dc, xc[2] + 6);
        end
        chk("basic_one_in_flight", overlap, 0);
        chk("basic_y_cnt", yq.size(), 3);
        if (yq.size() == 3) begin
            chk("basic_y0", yq[0], 17'h00101);
            chk("basic_y1", yq[1], 17'h00201);
            chk("basic_y2", yq[2], 17'h10301);
        end
        chk("basic_done_pulses", dn, 1);

        clr_logs();
        m_y_ready = 1'b0;
        push(16'h0010);
        push(16'h0020);
        push(16'h0030);
        push(16'h0040);
        go(16'd4, 1'b0, s);
        repeat (60) tick();
        chk("bp_stalled_issues", xq.size(), 2);
        chk("bp_busy", busy, 1);
        chk("bp_head", {m_y_valid, m_y_last, m_y_data}, 18'h20011);
        if (xq.size() > 0) chk("bp_x0_cycle", xc[0], s + 2);
        m_y_ready = 1'b1;
        wait_done("bp_done");
        tick();
        chk("bp_x_cnt", xq.size(), 4);
        chk("bp_y_cnt", yq.size(), 4);
        if (yq.size() == 4) begin
            chk("bp_y0", yq[0], 17'h00011);
            chk("bp_y1", yq[1], 17'h00021);
            chk("bp_y2", yq[2], 17'h00031);
            chk("bp_y3", yq[3], 17'h10041);
        end

        clr_logs();
        go(16'd0, 1'b1, s);
        chk("zero_done_c1", done, 1);
        chk("zero_busy_c1", busy, 1);
        cfg_seq_len = 16'd5;
        cfg_clear_state = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done_c2", done, 0);
        chk("zero_busy_c2", busy, 0);
        repeat (10) tick();
        chk("zero_no_x", xq.size(), 0);
        chk("zero_no_strobe", sq.size(), 0);
        chk("zero_done_pulses", dn, 1);
        chk("ignored_start_idle", busy, 0);

        clr_logs();
        push(16'h0500);
        go(16'd1, 1'b1, s);
        tick();
        lstm_ready = 1'b0;
        repeat (3) tick();
        lstm_ready = 1'b1;
        wait_done("pause_done");
        tick();
        chk("pause_strobe_cnt", sq.size(), 4);
        if (sq.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("pause_strobe_layer", sq[i], 4'b0001 << i);
            chk("pause_gap", sc[1], sc[0] + 4);
            chk("pause_resume", sc[3], sc[1] + 2);
        end
        chk("pause_y_cnt", yq.size(), 1);
        if (yq.size() == 1) chk("pause_y", yq[0], 17'h10501);

        clr_logs();
        push(16'h0600);
        push(16'h0700);
        go(16'd2, 1'b0, s);
        repeat (2) tick();
        chk("mid_in_wait", {busy, xq.size() == 1}, 2'b11);
        rst_n = 1'b0;
        gen++;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_m_y_valid", m_y_valid, 0);
        chk("mid_rst_s_x_ready", s_x_ready, 1);
        chk("mid_rst_perr", protocol_err, 0);
        chk("mid_rst_x_valid", x_in_valid, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        clr_logs();
        push(16'h0800);
        go(16'd1, 1'b0, s);
        wait_done("post_rst_done");
        tick();
        chk("post_rst_x_cnt", xq.size(), 1);
        if (xq.size() == 1) chk("post_rst_x", xq[0], 16'h0800);
        chk("post_rst_y_cnt", yq.size(), 1);
        if (yq.size() == 1) chk("post_rst_y", yq[0], 17'h10801);
        chk("post_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
